// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshaking.
// The operand is split into BLOCK-bit lookahead groups; each pipeline stage
// resolves WIDTH/(BLOCK*STAGES) consecutive groups, rippling the group carry
// inside the stage and registering it for the next stage.
module pipe_cla_addsub #(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF
);

  localparam int NGRP = WIDTH / BLOCK;
  localparam int GPS  = NGRP / STAGES;

  // One lookahead group: every internal carry is a flat sum-of-products of the
  // group's generate/propagate terms and the incoming carry (no internal ripple).
  function automatic logic [BLOCK:0] cla_group(
    input logic [BLOCK-1:0] a,
    input logic [BLOCK-1:0] b,
    input logic             cin
  );
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             t;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int j = 1; j <= BLOCK; j++) begin
      t = cin;
      for (int m = 0; m < j; m++) t = t & p[m];
      c[j] = t;
      for (int i = 0; i < j; i++) begin
        t = g[i];
        for (int m = i + 1; m < j; m++) t = t & p[m];
        c[j] = c[j] | t;
      end
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;

  logic [STAGES-1:0][WIDTH-1:0] a_pipe;
  logic [STAGES-1:0][WIDTH-1:0] b_pipe;
  logic [STAGES-1:0][WIDTH-1:0] s_pipe;
  logic [STAGES-1:0]            c_pipe;

  // A stage advances if it or any stage downstream of it is empty, or the
  // output is being taken; computed from the tail back to stage 0.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain  = chain | !valid_q[k];
      adv[k] = chain;
    end
  end

  // Valid bits follow the data: each advancing stage takes its upstream valid.
  always_comb begin
    valid_d = valid_q;
    if (adv[0]) valid_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) valid_d[k] = valid_q[k-1];
    end
  end

  // Valid register; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_d;
    logic             c_q;

    if (k == 0) begin : g_head
      // Stage 0 forms the effective operands; subtract is A + ~B + 1.
      always_comb begin
        a_src = A;
        b_src = SUB ? ~B : B;
        c_src = SUB ? 1'b1 : CI;
        s_src = '0;
      end
    end else begin : g_body
      // Later stages continue from the previous stage's registers.
      always_comb begin
        a_src = a_pipe[k-1];
        b_src = b_pipe[k-1];
        c_src = c_pipe[k-1];
        s_src = s_pipe[k-1];
      end
    end

    // Resolve this stage's groups, rippling the group carry across them.
    always_comb begin
      logic           cy;
      logic [BLOCK:0] r;
      a_d = a_src;
      b_d = b_src;
      s_d = s_src;
      cy  = c_src;
      r   = '0;
      for (int gi = 0; gi < GPS; gi++) begin
        r  = cla_group(a_src[(k*GPS+gi)*BLOCK +: BLOCK],
                       b_src[(k*GPS+gi)*BLOCK +: BLOCK], cy);
        s_d[(k*GPS+gi)*BLOCK +: BLOCK] = r[BLOCK-1:0];
        cy = r[BLOCK];
      end
      c_d = cy;
    end

    // Stage datapath register, loaded whenever the stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv[k]) begin
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    assign a_pipe[k] = a_q;
    assign b_pipe[k] = b_q;
    assign s_pipe[k] = s_q;
    assign c_pipe[k] = c_q;
  end

  // Only the sign bits of the final operands matter for overflow; the rest
  // have already been folded into the sum.
  logic unused_final_operands;
  assign unused_final_operands = ^{a_pipe[STAGES-1][WIDTH-2:0], b_pipe[STAGES-1][WIDTH-2:0]};

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign S         = out_valid ? s_pipe[STAGES-1] : '0;
  assign CO        = out_valid & c_pipe[STAGES-1];
  assign OVF       = out_valid
                   & (a_pipe[STAGES-1][WIDTH-1] == b_pipe[STAGES-1][WIDTH-1])
                   & (s_pipe[STAGES-1][WIDTH-1] != a_pipe[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub: three instances (STAGES = 1, 2, 4) share one
// input stream; each has its own expected-result queue fed from an arithmetic
// reference model, plus directed vectors and multi-cycle corner sequences.
module tb_pipe_cla_addsub;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    res_t         exp;
  } vec_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic         CI        = 1'b0;
  logic         SUB       = 1'b0;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;

  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         co_w        [3];
  logic         ovf_w       [3];
  logic [W-1:0] s_w         [3];

  int   checks   = 0;
  int   failures = 0;
  res_t sb [3][64];
  int   wr [3] = '{default: 0};
  int   rd [3] = '{default: 0};
  logic hold_pend [3] = '{default: 1'b0};
  res_t held [3];

  always #5 clk = ~clk;

  pipe_cla_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .A(A), .B(B), .CI(CI), .SUB(SUB), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .S(s_w[0]), .CO(co_w[0]), .OVF(ovf_w[0]));

  pipe_cla_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .A(A), .B(B), .CI(CI), .SUB(SUB), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .S(s_w[1]), .CO(co_w[1]), .OVF(ovf_w[1]));

  pipe_cla_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .A(A), .B(B), .CI(CI), .SUB(SUB), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .S(s_w[2]), .CO(co_w[2]), .OVF(ovf_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    res_t r;
    int   sr;
    int   ur;
    if (sub) begin
      sr   = int'($signed(a)) - int'($signed(b));
      r.co = (a >= b);
    end else begin
      sr   = int'($signed(a)) + int'($signed(b)) + int'(ci);
      ur   = int'(a) + int'(b) + int'(ci);
      r.co = (ur > 65535);
    end
    r.s   = sr[W-1:0];
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  function automatic res_t cur(input int d);
    res_t r;
    r.s   = s_w[d];
    r.co  = co_w[d];
    r.ovf = ovf_w[d];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        wr[d]        = 0;
        rd[d]        = 0;
        hold_pend[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        res_t now_r;
        now_r = cur(d);
        if (hold_pend[d]) begin
          chk($sformatf("d%0d_hold_valid", d), 32'(out_valid_w[d]), 32'd1);
          chk($sformatf("d%0d_hold_data", d), 32'(now_r), 32'(held[d]));
        end
        if (!out_valid_w[d]) chk($sformatf("d%0d_idle_zero", d), 32'(now_r), 32'd0);
        hold_pend[d] = out_valid_w[d] && !out_ready;
        held[d]      = now_r;
        if (out_valid_w[d] && out_ready) begin
          if (rd[d] == wr[d]) begin
            checks++;
            failures++;
            $display("FAIL d%0d_unexpected_out actual=0x%0h required=no result", d, now_r);
          end else begin
            chk($sformatf("d%0d_result", d), 32'(now_r), 32'(sb[d][rd[d] % 64]));
            rd[d]++;
          end
        end
        if (in_valid && in_ready_w[d]) begin
          sb[d][wr[d] % 64] = model(A, B, CI, SUB);
          wr[d]++;
        end
      end
    end
  end

  vec_t tbl [8];

  task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub,
                         input logic [W-1:0] s, input logic co, input logic ovf);
    tbl[i].a       = a;
    tbl[i].b       = b;
    tbl[i].ci      = ci;
    tbl[i].sub     = sub;
    tbl[i].exp.s   = s;
    tbl[i].exp.co  = co;
    tbl[i].exp.ovf = ovf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sa [6];
    logic [W-1:0] sbv [6];
    logic         ssub [6];
    res_t         sexp [6];
    int           idx;
    int           got;
    logic         saw_block;

    set_vec(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    set_vec(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    set_vec(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    set_vec(3, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    set_vec(4, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    set_vec(5, 16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    set_vec(6, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    set_vec(7, 16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_rst_out_valid", d), 32'(out_valid_w[d]), 32'd0);
      chk($sformatf("d%0d_rst_in_ready", d), 32'(in_ready_w[d]), 32'd1);
      chk($sformatf("d%0d_rst_outputs", d), 32'(cur(d)), 32'd0);
    end
    #20 rst_n = 1'b1;

    // Directed vectors with latency checks.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      A = tbl[i].a; B = tbl[i].b; CI = tbl[i].ci; SUB = tbl[i].sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_s1_valid", i), 32'(out_valid_w[0]), 32'd1);
      chk($sformatf("vec%0d_s1_res", i), 32'(cur(0)), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_s2_early", i), 32'(out_valid_w[1]), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_s2_valid", i), 32'(out_valid_w[1]), 32'd1);
      chk($sformatf("vec%0d_s2_res", i), 32'(cur(1)), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_s4_early", i), 32'(out_valid_w[2]), 32'd0);
    end

    // Six back-to-back ops with the output stalled in cycles 3..6.
    for (int i = 0; i < 6; i++) begin
      sa[i]   = W'(16'h1111 * i + 16'h0F0F);
      sbv[i]  = W'(16'h0707 * i + 16'h00F3);
      ssub[i] = i[0];
      sexp[i] = model(sa[i], sbv[i], 1'b1, ssub[i]);
    end
    idx = 0; got = 0; saw_block = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        A = sa[idx]; B = sbv[idx]; CI = 1'b1; SUB = ssub[idx];
      end
      @(negedge clk);
      if (!in_ready_w[1]) saw_block = 1'b1;
      if (in_valid && in_ready_w[1]) idx++;
      if (out_valid_w[1] && out_ready) begin
        chk($sformatf("stream_res%0d", got), 32'(cur(1)), 32'(sexp[got]));
        got++;
      end
    end
    chk("stream_count", 32'(got), 32'd6);
    chk("stream_accepted", 32'(idx), 32'd6);
    chk("stream_in_ready_dropped", 32'(saw_block), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Reset with two operations in flight.
    #1;
    A = 16'h1234; B = 16'h4321; CI = 1'b0; SUB = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    A = 16'h0F00; B = 16'h00F0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(out_valid_w[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_midrst_out_valid", d), 32'(out_valid_w[d]), 32'd0);
      chk($sformatf("d%0d_midrst_in_ready", d), 32'(in_ready_w[d]), 32'd1);
    end
    @(negedge clk); #2;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk($sformatf("d%0d_no_stale", d), 32'(out_valid_w[d]), 32'd0);
    end

    // Random sweep with random backpressure on all three depths.
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = rand_op();
      B         = rand_op();
      CI        = 1'($urandom_range(0, 1));
      SUB       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_drained", d), 32'(wr[d] - rd[d]), 32'd0);
      chk($sformatf("d%0d_enough_results", d), 32'(rd[d] > 100), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_cla_addsub.md
PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits, legal only as a multiple of BLOCK.
REQ-002 The block SHALL have parameter BLOCK, default 4, meaning bits per carry-lookahead group.
REQ-003 The block SHALL have parameter STAGES, default 2, meaning pipeline depth, legal 1..WIDTH/BLOCK, with WIDTH/BLOCK divisible by STAGES.
REQ-004 clk  input  1  rising-edge clock; the block has one clock only.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  A, B, CI, SUB are valid this cycle.
REQ-007 in_ready  output  1  block accepts an operation this cycle.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 CI  input  1  carry-in, used only when SUB=0.
REQ-011 SUB  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  S, CO, OVF hold a result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 S  output  WIDTH  sum or difference.
REQ-015 CO  output  1  carry-out of the MSB group (for SUB, 1 = no borrow).
REQ-016 OVF  output  1  two's-complement signed overflow.

Function
REQ-017 Effective operands SHALL be Beff = SUB ? ~B : B and Cin = SUB ? 1 : CI, so {CO,S} = A + Beff + Cin modulo 2^(WIDTH+1).
REQ-018 Each BLOCK-bit group SHALL compute generate/propagate and a lookahead group carry; ripple between groups is permitted only within a stage.
REQ-019 Stage k (0..STAGES-1) SHALL resolve groups k*G..(k+1)*G-1, where G = WIDTH/(BLOCK*STAGES), and register the partial sum, the inter-stage carry and the unprocessed operand bits.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid & in_ready at an edge) to out_valid, with no stall.
REQ-021 Each stage SHALL hold a valid bit and SHALL advance when it is empty or the next stage (or the output, for the last stage) is advancing.
REQ-022 in_ready SHALL equal !valid[0] | advance[0], giving a combinational path from out_ready to in_ready.
REQ-023 With out_ready held at 1, throughput SHALL be one result per cycle.
REQ-024 With out_ready=0 and out_valid=1, S, CO and OVF SHALL hold stable, and the pipe SHALL fill until in_ready=0 with no data lost or duplicated.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 OVF SHALL be (A[MSB] == Beff[MSB]) & (S[MSB] != A[MSB]).
REQ-027 An input presented with in_ready=0 SHALL be ignored; the source must hold it.
REQ-028 Simultaneous acceptance at the input and release at the output in one cycle SHALL both take effect.

Reset
REQ-029 On rst_n low, all valid bits SHALL clear immediately (asynchronously), discarding in-flight operations, so out_valid=0 and in_ready=1.
REQ-030 Reset SHALL set S=0, CO=0 and OVF=0; datapath registers MAY reset, but their outputs SHALL read 0 while out_valid=0.
REQ-031 The first acceptance SHALL occur at the first rising edge after rst_n deasserts with in_valid=1.

Verification
REQ-032 Test: WIDTH=16, STAGES=2, out_ready=1, add A=0x00FF, B=0x0001, CI=0 -> after 2 cycles S=0x0100, CO=0, OVF=0.
REQ-033 Test: add A=0xFFFF, B=0x0000, CI=1 -> S=0x0000, CO=1 (carry crosses every group and stage); then A=0x7FFF, B=0x0001 -> S=0x8000, OVF=1.
REQ-034 Test: SUB=1 with A=0x0005, B=0x0007 -> S=0xFFFE, CO=0; then A=0x8000, B=0x0001 -> S=0x7FFF, OVF=1, CO=1.
REQ-035 Test: stream 6 ops back-to-back, out_ready=0 for cycles 3-6 -> in_ready drops after pipe and output full, all 6 results appear in order, none lost or duplicated.
REQ-036 Test: assert rst_n=0 mid-stream with 2 ops in flight -> out_valid=0 the same cycle, no stale result after release.
REQ-037 Test: random sweep over STAGES in {1,2,4} with random backpressure, checked against the A+Beff+Cin reference model.
